// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: resolves the immediate format, extends the
// immediate to XLEN and presents it through a one-deep register plus skid buffer.
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 6,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [3:0]       sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [3:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [3:0] FMT_I    = 4'd0;
    localparam logic [3:0] FMT_IZ   = 4'd1;
    localparam logic [3:0] FMT_SH   = 4'd2;
    localparam logic [3:0] FMT_S    = 4'd3;
    localparam logic [3:0] FMT_B    = 4'd4;
    localparam logic [3:0] FMT_U    = 4'd5;
    localparam logic [3:0] FMT_J    = 4'd6;
    localparam logic [3:0] FMT_FL   = 4'd7;
    localparam logic [3:0] FMT_FS   = 4'd8;
    localparam logic [3:0] FMT_BAD  = 4'd9;
    localparam logic [3:0] FMT_NONE = 4'd15;

    function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [3:0] auto_fmt(input logic [6:0] op, input logic [2:0] f3);
        logic [3:0] f;
        f = FMT_BAD;
        case (op)
            7'b0010011: begin
                if (f3 == 3'b001 || f3 == 3'b101) f = FMT_SH;
                else if (f3 == 3'b011)            f = FMT_IZ;
                else                              f = FMT_I;
            end
            7'b0000011, 7'b1100111: f = FMT_I;
            7'b0100011:             f = FMT_S;
            7'b1100011:             f = FMT_B;
            7'b0110111, 7'b0010111: f = FMT_U;
            7'b1101111:             f = FMT_J;
            7'b0000111:             f = FMT_FL;
            7'b0100111:             f = FMT_FS;
            7'b0110011, 7'b1010011, 7'b0111011,
            7'b0001111, 7'b1110011: f = FMT_NONE;
            default:                f = FMT_BAD;
        endcase
        return f;
    endfunction

    // stage p0: combinational format resolution and extension
    logic [3:0]             fmt_p0;
    logic                   ill_p0;
    logic signed [XLEN-1:0] imm_p0;

    always_comb begin
        fmt_p0 = AUTO_DECODE ? auto_fmt(inst[6:0], inst[14:12]) : sel;
        ill_p0 = (fmt_p0 >= FMT_BAD) && (fmt_p0 < FMT_NONE);
        imm_p0 = '0;
        case (fmt_p0)
            FMT_I, FMT_FL: imm_p0 = sext32({{20{inst[31]}}, inst[31:20]});
            FMT_IZ:        imm_p0 = zext32({20'b0, inst[31:20]});
            FMT_SH:        imm_p0 = (XLEN == 64) ? zext32({26'b0, inst[25:20]})
                                                 : zext32({27'b0, inst[24:20]});
            FMT_S, FMT_FS: imm_p0 = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
            FMT_B:         imm_p0 = sext32({{19{inst[31]}}, inst[31], inst[7],
                                            inst[30:25], inst[11:8], 1'b0});
            FMT_U:         imm_p0 = sext32({inst[31:12], 12'b0});
            FMT_J:         imm_p0 = sext32({{11{inst[31]}}, inst[31], inst[19:12],
                                            inst[20], inst[30:21], 1'b0});
            default:       imm_p0 = '0;
        endcase
    end

    // stage p1: main register plus skid register
    logic                   vld_p1, sk_vld_p1, rdy_p1;
    logic signed [XLEN-1:0] imm_p1, sk_imm_p1;
    logic [3:0]             fmt_p1, sk_fmt_p1;
    logic                   ill_p1, sk_ill_p1;
    logic [TAG_W-1:0]       tag_p1, sk_tag_p1;
    logic                   m_free, acc;

    assign m_free = !vld_p1 || out_ready;
    assign acc    = in_valid && rdy_p1;

    // in_ready mirrors !skid-valid but is held in its own flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            sk_vld_p1 <= 1'b0;
            rdy_p1    <= 1'b1;
            imm_p1    <= '0;
            fmt_p1    <= '0;
            ill_p1    <= 1'b0;
            tag_p1    <= '0;
            sk_imm_p1 <= '0;
            sk_fmt_p1 <= '0;
            sk_ill_p1 <= 1'b0;
            sk_tag_p1 <= '0;
        end else if (flush) begin
            vld_p1    <= 1'b0;
            sk_vld_p1 <= 1'b0;
            rdy_p1    <= 1'b1;
        end else if (m_free) begin
            if (sk_vld_p1) begin
                vld_p1    <= 1'b1;
                imm_p1    <= sk_imm_p1;
                fmt_p1    <= sk_fmt_p1;
                ill_p1    <= sk_ill_p1;
                tag_p1    <= sk_tag_p1;
                sk_vld_p1 <= 1'b0;
                rdy_p1    <= 1'b1;
            end else begin
                vld_p1 <= acc;
                if (acc) begin
                    imm_p1 <= imm_p0;
                    fmt_p1 <= fmt_p0;
                    ill_p1 <= ill_p0;
                    tag_p1 <= in_tag;
                end
            end
        end else if (acc) begin
            sk_vld_p1 <= 1'b1;
            sk_imm_p1 <= imm_p0;
            sk_fmt_p1 <= fmt_p0;
            sk_ill_p1 <= ill_p0;
            sk_tag_p1 <= in_tag;
            rdy_p1    <= 1'b0;
        end
    end

    assign in_ready    = rdy_p1;
    assign out_valid   = vld_p1;
    assign imm         = imm_p1;
    assign out_fmt     = fmt_p1;
    assign out_illegal = ill_p1;
    assign out_tag     = tag_p1;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Takes a full 32-bit instruction, derives the immediate format from the opcode or from an external selector, and outputs the sign- or zero-extended immediate at XLEN width. A valid/ready handshake and a registered-ready skid buffer let it sit between fetch/decode and rename/dispatch under backpressure and flush.

## Interface
- XLEN, 32 — immediate width; legal values are 32 and 64.
- TAG_W, 6 — width of the sideband tag (ROB/PC index) carried alongside the instruction.
- AUTO_DECODE, 1 — 1: format derived from opcode/funct3; 0: format taken from `sel`.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all in-flight entries.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept; registered.
- inst  in  32  instruction, standard RISC-V bit positions.
- sel  in  4  format code; used only when AUTO_DECODE=0.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- imm  out  XLEN  extended immediate.
- out_fmt  out  4  resolved format code.
- out_illegal  out  1  opcode or `sel` not recognised.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Format codes:
  - 0 I: sign-extend inst[31:20].
  - 1 IZ: zero-extend inst[31:20].
  - 2 SH: shamt = inst[24:20] when XLEN=32, inst[25:20] when XLEN=64; zero-extended.
  - 3 S: sign-extend {inst[31:25], inst[11:7]}.
  - 4 B: sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 5 U: {inst[31:12], 12'b0}, sign-extended to XLEN.
  - 6 J: sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - 7 FL: same as I.
  - 8 FS: same as S.
  - 15 NONE: imm=0, out_illegal=0.
  - 9–14 illegal: imm=0, out_illegal=1.
- AUTO_DECODE=1, keyed on inst[6:0]:
  - 0010011 with funct3=001 or 101 → SH.
  - 0010011 with funct3=011 → IZ. This is the team's sltiu convention.
  - 0010011 otherwise → I.
  - 0000011 or 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111 or 0010111 → U.
  - 1101111 → J.
  - 0000111 → FL.
  - 0100111 → FS.
  - 0110011, 1010011, 0111011, 0001111, 1110011 → NONE.
  - Anything else → out_fmt=9, out_illegal=1.
- Immediate computation is combinational on the input side. The result is captured together with the tag into the stage register.
- Buffering: a main register (M) and a skid register (K), each with a valid bit.
  - in_ready = !K.valid, taken from a register.
  - Accept when in_valid && in_ready.
  - Output is always driven from M.
  - When M empties or its entry drains, K moves into M before any new input.
  - An accept while M is held (out_valid && !out_ready) fills K.
- Order is strictly FIFO. No entry is dropped or duplicated.
- flush clears M.valid and K.valid on the next edge. An input presented in the same cycle as flush is discarded. flush has priority over every transfer.

## Timing
- Latency is 1 cycle: an input accepted at edge N is visible on the outputs after edge N.
- Throughput is 1 per cycle while out_ready=1.
- After K fills, in_ready drops on the next cycle. It rises one cycle after K drains into M.
- Reset, asynchronous:
  - out_valid=0, imm=0, out_fmt=0, out_illegal=0, out_tag=0.
  - Both valid bits 0.
  - in_ready=1 during and after reset.
- Reset or flush mid-stream loses all buffered entries. The first input after release is accepted normally.
- The outputs imm, out_fmt, out_illegal and out_tag hold stable while out_valid && !out_ready.
- Simultaneous drain and accept with K empty: M reloads from the input with no bubble.

## Test plan
- XLEN=32, AUTO_DECODE=1, out_ready=1:
  - 0xFFF00093 (addi −1) → imm 0xFFFFFFFF, fmt 0.
  - 0xFFF03093 (sltiu) → imm 0x00000FFF, fmt 1.
  - 0x01F01093 (slli 31) → imm 0x0000001F, fmt 2. Each result appears one cycle after accept.
- Branch and jump: 0xFE000EE3 (beq −4) → imm 0xFFFFFFFC, fmt 4; 0x001000EF (jal +2048) → imm 0x00000800, fmt 6.
- XLEN=64: 0x800002B7 (lui 0x80000) → imm 0xFFFFFFFF80000000, fmt 5. An instruction with opcode 0x7F → out_illegal=1, imm 0, fmt 9.
- Backpressure:
  - Stimulus: 4 back-to-back inputs with tags 1–4; out_ready=0 for 3 cycles, then 1.
  - Tags 1 and 2 are accepted; in_ready drops before tag 3.
  - Outputs then appear in order 1, 2, 3, 4, with no loss and no duplicates.
- Flush and reset:
  - With M and K full, assert flush together with in_valid → out_valid=0 next cycle, in_ready=1, the presented input is dropped.
  - Repeat using asynchronous rst asserted mid-cycle → all outputs 0 immediately.
- AUTO_DECODE=0: sel=3 with 0xFE112E23 → imm 0xFFFFFFFC (S); sel=12 → out_illegal=1, imm 0.
